// File: rtl/axil_demo_pkg.sv
// Shared response codes and sizing helpers for the demo AXI4-Lite register slave.
package axil_demo_pkg;

   typedef logic [1:0] axil_resp_t;

   localparam axil_resp_t RESP_OKAY   = 2'b00;
   localparam axil_resp_t RESP_SLVERR = 2'b10;

   // Word index is the byte address without its two low bits; keep at least one bit.
   function automatic int reg_idx_width(input int addr_width);
      return (addr_width > 2) ? (addr_width - 2) : 1;
   endfunction

endpackage

// File: rtl/axil_demo_regfile.sv
// Byte-strobed register array with a one-cycle per-register write pulse and a combinational read port.
module axil_demo_regfile
   import axil_demo_pkg::*;
#(
   parameter int          NUM_REGS  = 4,
   parameter int          IDX_W     = 2,
   parameter logic [31:0] RESET_VAL = 32'h0
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_wr_en,
   input  logic [IDX_W-1:0]       i_wr_idx,
   input  logic [31:0]            i_wr_data,
   input  logic [3:0]             i_wr_strb,
   input  logic [IDX_W-1:0]       i_rd_idx,
   output logic [31:0]            o_rd_data,
   output logic [NUM_REGS*32-1:0] o_reg_out,
   output logic [NUM_REGS-1:0]    o_wr_pulse
);

   logic [31:0]         r_regs [NUM_REGS];
   logic [NUM_REGS-1:0] r_wr_pulse;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            r_regs[k] <= RESET_VAL;
         end
         r_wr_pulse <= '0;
      end else begin
         for (int k = 0; k < NUM_REGS; k++) begin
            r_wr_pulse[k] <= i_wr_en && (i_wr_idx == IDX_W'(k));
            if (i_wr_en && (i_wr_idx == IDX_W'(k))) begin
               for (int b = 0; b < 4; b++) begin
                  if (i_wr_strb[b]) begin
                     r_regs[k][8*b +: 8] <= i_wr_data[8*b +: 8];
                  end
               end
            end
         end
      end
   end

   // An index with no matching register reads as zero.
   always_comb begin
      o_rd_data = 32'h0;
      o_reg_out = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         o_reg_out[32*k +: 32] = r_regs[k];
         if (i_rd_idx == IDX_W'(k)) begin
            o_rd_data = r_regs[k];
         end
      end
   end

   assign o_wr_pulse = r_wr_pulse;

endmodule

// File: rtl/axil_demo_reg_slave.sv
// AXI4-Lite S00_AXI endpoint: independent AW/W holding slots, single outstanding B and R responses.
module axil_demo_reg_slave
   import axil_demo_pkg::*;
#(
   parameter int          DATA_WIDTH = 32,
   parameter int          ADDR_WIDTH = 4,
   parameter int          NUM_REGS   = 4,
   parameter logic [31:0] RESET_VAL  = 32'h0
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]              S_AXI_AWPROT,
   input  logic                    S_AXI_AWVALID,
   output logic                    S_AXI_AWREADY,
   input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                    S_AXI_WVALID,
   output logic                    S_AXI_WREADY,
   output axil_resp_t              S_AXI_BRESP,
   output logic                    S_AXI_BVALID,
   input  logic                    S_AXI_BREADY,
   input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]              S_AXI_ARPROT,
   input  logic                    S_AXI_ARVALID,
   output logic                    S_AXI_ARREADY,
   output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
   output axil_resp_t              S_AXI_RRESP,
   output logic                    S_AXI_RVALID,
   input  logic                    S_AXI_RREADY,
   output logic [NUM_REGS*32-1:0]  reg_out,
   output logic [NUM_REGS-1:0]     wr_pulse
);

   localparam int               IDX_W      = reg_idx_width(ADDR_WIDTH);
   localparam logic [IDX_W:0]   NUM_REGS_L = (IDX_W+1)'(NUM_REGS);

   logic                    r_aw_full;
   logic                    r_w_full;
   logic [ADDR_WIDTH-1:0]   r_awaddr;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [DATA_WIDTH/8-1:0] r_wstrb;
   logic                    r_bvalid;
   axil_resp_t              r_bresp;
   logic                    r_rvalid;
   logic [DATA_WIDTH-1:0]   r_rdata;
   axil_resp_t              r_rresp;

   logic                    w_aw_hs;
   logic                    w_w_hs;
   logic                    w_ar_hs;
   logic                    w_commit;
   logic [IDX_W-1:0]        w_aw_idx;
   logic [IDX_W-1:0]        w_ar_idx;
   logic                    w_aw_in_range;
   logic                    w_ar_in_range;
   logic [31:0]             w_rd_data;
   logic                    w_unused;

   assign w_aw_hs       = S_AXI_AWVALID && !r_aw_full;
   assign w_w_hs        = S_AXI_WVALID && !r_w_full;
   assign w_ar_hs       = S_AXI_ARVALID && !r_rvalid;
   assign w_commit      = r_aw_full && r_w_full && !r_bvalid;
   assign w_aw_idx      = IDX_W'(r_awaddr >> 2);
   assign w_ar_idx      = IDX_W'(S_AXI_ARADDR >> 2);
   assign w_aw_in_range = ({1'b0, w_aw_idx} < NUM_REGS_L);
   assign w_ar_in_range = ({1'b0, w_ar_idx} < NUM_REGS_L);
   assign w_unused      = ^{S_AXI_AWPROT, S_AXI_ARPROT};

   // Commit empties both slots; while a B response is pending, new AW/W may still fill them.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_aw_full <= 1'b0;
         r_w_full  <= 1'b0;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
      end else if (w_commit) begin
         r_aw_full <= 1'b0;
         r_w_full  <= 1'b0;
         r_bvalid  <= 1'b1;
         r_bresp   <= w_aw_in_range ? RESP_OKAY : RESP_SLVERR;
      end else begin
         if (w_aw_hs) begin
            r_aw_full <= 1'b1;
            r_awaddr  <= S_AXI_AWADDR;
         end
         if (w_w_hs) begin
            r_w_full <= 1'b1;
            r_wdata  <= S_AXI_WDATA;
            r_wstrb  <= S_AXI_WSTRB;
         end
         if (r_bvalid && S_AXI_BREADY) begin
            r_bvalid <= 1'b0;
         end
      end
   end

   // Read data is sampled at the AR edge, so a same-edge commit is not yet visible.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_rresp  <= RESP_OKAY;
      end else if (w_ar_hs) begin
         r_rvalid <= 1'b1;
         r_rdata  <= w_ar_in_range ? w_rd_data : '0;
         r_rresp  <= w_ar_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (r_rvalid && S_AXI_RREADY) begin
         r_rvalid <= 1'b0;
      end
   end

   axil_demo_regfile #(
      .NUM_REGS  (NUM_REGS),
      .IDX_W     (IDX_W),
      .RESET_VAL (RESET_VAL)
   ) u_regfile (
      .i_clk      (ACLK),
      .i_rst      (ARESET),
      .i_wr_en    (w_commit && w_aw_in_range),
      .i_wr_idx   (w_aw_idx),
      .i_wr_data  (r_wdata),
      .i_wr_strb  (r_wstrb),
      .i_rd_idx   (w_ar_idx),
      .o_rd_data  (w_rd_data),
      .o_reg_out  (reg_out),
      .o_wr_pulse (wr_pulse)
   );

   assign S_AXI_AWREADY = !r_aw_full;
   assign S_AXI_WREADY  = !r_w_full;
   assign S_AXI_ARREADY = !r_rvalid;
   assign S_AXI_BVALID  = r_bvalid;
   assign S_AXI_BRESP   = r_bresp;
   assign S_AXI_RVALID  = r_rvalid;
   assign S_AXI_RDATA   = r_rdata;
   assign S_AXI_RRESP   = r_rresp;

endmodule

// File: tb/tb_axil_demo_reg_slave.sv
// Directed bench: a 4-register and a 3-register slave driven by the same master stimulus.
module tb_axil_demo_reg_slave;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [3:0]  awaddr, araddr, wstrb;
   logic [2:0]  awprot, arprot;
   logic [31:0] wdata;
   logic        awvalid, wvalid, bready, arvalid, rready;

   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;
   logic [127:0] reg_out;
   logic [3:0]  wr_pulse;

   logic        awready3, wready3, bvalid3, arready3, rvalid3;
   logic [1:0]  bresp3, rresp3;
   logic [31:0] rdata3;
   logic [95:0] reg_out3;
   logic [2:0]  wr_pulse3;

   int n_tests = 0;
   int n_fail  = 0;

   logic [1:0]  last_bresp, last_bresp3, last_rresp, last_rresp3;
   logic [31:0] last_rdata, last_rdata3;
   logic [3:0]  last_pulse;
   logic [2:0]  last_pulse3;

   axil_demo_reg_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_REGS(4), .RESET_VAL(32'h0)) u_dut (
      .ACLK(clk), .ARESET(rst),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .reg_out(reg_out), .wr_pulse(wr_pulse)
   );

   axil_demo_reg_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_REGS(3), .RESET_VAL(32'h0)) u_dut3 (
      .ACLK(clk), .ARESET(rst),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready3),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready3),
      .S_AXI_BRESP(bresp3), .S_AXI_BVALID(bvalid3), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready3),
      .S_AXI_RDATA(rdata3), .S_AXI_RRESP(rresp3), .S_AXI_RVALID(rvalid3), .S_AXI_RREADY(rready),
      .reg_out(reg_out3), .wr_pulse(wr_pulse3)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      logic aw_rdy, w_rdy;
      awaddr = a; wdata = d; wstrb = s;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      for (int n = 0; n < 20 && (awvalid || wvalid); n++) begin
         aw_rdy = awready;
         w_rdy  = wready;
         step();
         if (aw_rdy) awvalid = 1'b0;
         if (w_rdy)  wvalid  = 1'b0;
      end
      for (int n = 0; n < 20 && !bvalid; n++) step();
      chk("wr_bvalid", 128'(bvalid), 128'(1'b1));
      last_bresp  = bresp;
      last_bresp3 = bresp3;
      last_pulse  = wr_pulse;
      last_pulse3 = wr_pulse3;
      step();
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [3:0] a);
      logic ar_rdy;
      araddr = a; arvalid = 1'b1; rready = 1'b1;
      for (int n = 0; n < 20 && arvalid; n++) begin
         ar_rdy = arready;
         step();
         if (ar_rdy) arvalid = 1'b0;
      end
      for (int n = 0; n < 20 && !rvalid; n++) step();
      chk("rd_rvalid", 128'(rvalid), 128'(1'b1));
      last_rdata  = rdata;
      last_rresp  = rresp;
      last_rdata3 = rdata3;
      last_rresp3 = rresp3;
      step();
      rready = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      awaddr = 4'h0; araddr = 4'h0; wstrb = 4'h0; awprot = 3'd0; arprot = 3'd0; wdata = 32'h0;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();

      // Reset state
      chk("rst_awready", 128'(awready), 128'(1'b1));
      chk("rst_wready", 128'(wready), 128'(1'b1));
      chk("rst_arready", 128'(arready), 128'(1'b1));
      chk("rst_bvalid", 128'(bvalid), 128'(1'b0));
      chk("rst_rvalid", 128'(rvalid), 128'(1'b0));
      chk("rst_resp", 128'({bresp, rresp}), 128'(4'h0));
      chk("rst_rdata", 128'(rdata), 128'(32'h0));
      chk("rst_wr_pulse", 128'(wr_pulse), 128'(4'h0));
      chk("rst_reg_out", reg_out, 128'h0);

      // Basic write / read-back
      axi_write(4'h0, 32'h1, 4'hF);
      chk("w0_bresp", 128'(last_bresp), 128'(2'b00));
      chk("w0_pulse", 128'(last_pulse), 128'(4'b0001));
      axi_write(4'h4, 32'h2, 4'hF);
      chk("w1_bresp", 128'(last_bresp), 128'(2'b00));
      axi_write(4'h8, 32'h3, 4'hF);
      chk("w2_bresp", 128'(last_bresp), 128'(2'b00));
      axi_write(4'hC, 32'h4, 4'hF);
      chk("w3_bresp", 128'(last_bresp), 128'(2'b00));
      chk("w3_pulse", 128'(last_pulse), 128'(4'b1000));
      axi_read(4'h0);
      chk("r0_data", 128'(last_rdata), 128'(32'h1));
      chk("r0_resp", 128'(last_rresp), 128'(2'b00));
      axi_read(4'h4);
      chk("r1_data", 128'(last_rdata), 128'(32'h2));
      axi_read(4'h8);
      chk("r2_data", 128'(last_rdata), 128'(32'h3));
      axi_read(4'hF);
      chk("r3_unaligned_data", 128'(last_rdata), 128'(32'h4));
      chk("r3_resp", 128'(last_rresp), 128'(2'b00));
      chk("basic_reg_out", reg_out, 128'h00000004_00000003_00000002_00000001);

      // W arrives three cycles ahead of AW
      wdata = 32'h5A5A5A5A; wstrb = 4'hF; wvalid = 1'b1; awvalid = 1'b0; bready = 1'b0;
      step();
      wvalid = 1'b0;
      chk("wfirst_wready_low", 128'(wready), 128'(1'b0));
      step();
      step();
      chk("wfirst_wready_held", 128'(wready), 128'(1'b0));
      chk("wfirst_no_bvalid", 128'(bvalid), 128'(1'b0));
      awaddr = 4'h8; awvalid = 1'b1;
      step();
      awvalid = 1'b0;
      chk("wfirst_bvalid_not_yet", 128'(bvalid), 128'(1'b0));
      step();
      chk("wfirst_bvalid", 128'(bvalid), 128'(1'b1));
      chk("wfirst_pulse", 128'(wr_pulse), 128'(4'b0100));
      chk("wfirst_reg2", 128'(reg_out[95:64]), 128'(32'h5A5A5A5A));
      bready = 1'b1;
      step();
      bready = 1'b0;
      chk("wfirst_pulse_gone", 128'(wr_pulse), 128'(4'b0000));
      chk("wfirst_bvalid_clr", 128'(bvalid), 128'(1'b0));

      // Byte strobes
      axi_write(4'h4, 32'h11223344, 4'hF);
      axi_write(4'h4, 32'hAABBCCDD, 4'b0010);
      chk("strb_reg1", 128'(reg_out[63:32]), 128'(32'h1122CC44));

      // Out-of-range index on the 3-register instance
      axi_write(4'hC, 32'hDEADBEEF, 4'hF);
      chk("oor_bresp3", 128'(last_bresp3), 128'(2'b10));
      chk("oor_pulse3", 128'(last_pulse3), 128'(3'b000));
      chk("oor_bresp4", 128'(last_bresp), 128'(2'b00));
      chk("oor_regs3", 128'(reg_out3), 128'(96'h5A5A5A5A_1122CC44_00000001));
      axi_read(4'hC);
      chk("oor_rdata3", 128'(last_rdata3), 128'(32'h0));
      chk("oor_rresp3", 128'(last_rresp3), 128'(2'b10));
      chk("oor_rdata4", 128'(last_rdata), 128'(32'hDEADBEEF));

      // B back-pressure with a second write queued behind it
      awaddr = 4'h0; wdata = 32'hA1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      step();
      awvalid = 1'b0; wvalid = 1'b0;
      step();
      chk("bp_bvalid1", 128'(bvalid), 128'(1'b1));
      chk("bp_reg0", 128'(reg_out[31:0]), 128'(32'hA1));
      awaddr = 4'h4; wdata = 32'hB2; awvalid = 1'b1; wvalid = 1'b1;
      step();
      awvalid = 1'b0; wvalid = 1'b0;
      chk("bp_awready_low", 128'(awready), 128'(1'b0));
      chk("bp_wready_low", 128'(wready), 128'(1'b0));
      for (int i = 0; i < 4; i++) begin
         step();
         chk("bp_bvalid_held", 128'(bvalid), 128'(1'b1));
         chk("bp_bresp_held", 128'(bresp), 128'(2'b00));
         chk("bp_awready_held", 128'(awready), 128'(1'b0));
      end
      bready = 1'b1;
      step();
      chk("bp_bvalid_clr", 128'(bvalid), 128'(1'b0));
      chk("bp_reg1_old", 128'(reg_out[63:32]), 128'(32'h1122CC44));
      step();
      chk("bp_bvalid2", 128'(bvalid), 128'(1'b1));
      chk("bp_reg1_new", 128'(reg_out[63:32]), 128'(32'hB2));
      chk("bp_pulse2", 128'(wr_pulse), 128'(4'b0010));
      step();
      bready = 1'b0;
      chk("bp_bvalid2_clr", 128'(bvalid), 128'(1'b0));

      // Asynchronous reset with AW held and a read response pending
      awaddr = 4'h8; awvalid = 1'b1; araddr = 4'h0; arvalid = 1'b1; rready = 1'b0;
      step();
      awvalid = 1'b0; arvalid = 1'b0;
      chk("mid_awready_low", 128'(awready), 128'(1'b0));
      chk("mid_rvalid", 128'(rvalid), 128'(1'b1));
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rvalid_clr", 128'(rvalid), 128'(1'b0));
      chk("mid_awready", 128'(awready), 128'(1'b1));
      chk("mid_reg_out", reg_out, 128'h0);
      chk("mid_reg_out3", 128'(reg_out3), 128'(96'h0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
      step();
      wvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_rst_no_bvalid", 128'(bvalid), 128'(1'b0));
      end
      chk("post_rst_regs", reg_out, 128'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
